// File: rtl/vga_pkg.sv
// Shared VGA framebuffer definitions: the grant encoding, RGB565 field layout and the
// default framebuffer geometry.
package vga_pkg;

   localparam int unsigned FB_AW = 17;   // 320x240 = 76800 words
   localparam int unsigned FB_DW = 16;

   localparam int unsigned RGB_R_W   = 5;
   localparam int unsigned RGB_R_OFS = 11;
   localparam int unsigned RGB_G_W   = 6;
   localparam int unsigned RGB_G_OFS = 5;
   localparam int unsigned RGB_B_W   = 5;
   localparam int unsigned RGB_B_OFS = 0;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_RD   = 2'd1,
      GNT_WR   = 2'd2
   } grant_e;

endpackage

// File: rtl/vga_rd_lat_pipe.sv
// Valid-only delay line that marks which RAM read-data cycles belong to an issued read.
module vga_rd_lat_pipe #(
   parameter int unsigned LAT = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_valid,
   output logic o_valid
);

   logic [LAT-1:0] r_sr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sr <= '0;
      end else begin
         r_sr[0] <= i_valid;
         for (int unsigned i = 1; i < LAT; i++) begin
            r_sr[i] <= r_sr[i-1];
         end
      end
   end

   assign o_valid = r_sr[LAT-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter between the VGA scan-out reader and the drawing writer;
// one RAM access per clock, read data returned in grant order.
module vga_fb_arbiter
   import vga_pkg::*;
#(
   parameter int unsigned AW         = FB_AW,
   parameter int unsigned DW         = FB_DW,
   parameter int unsigned MEM_RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          disp_vblank,
   input  logic          disp_urgent,
   input  logic          rd_valid,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_ready,
   output logic          rd_data_valid,
   output logic [DW-1:0] rd_data,
   input  logic          wr_valid,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ready,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          stat_clr,
   output logic [15:0]   stat_wr_stall
);

   grant_e r_last_grant;
   grant_e w_grant;
   logic   w_mem_rd;

   always_comb begin
      w_grant = GNT_NONE;
      if (rd_valid && disp_urgent) begin
         w_grant = GNT_RD;
      end else if (wr_valid && disp_vblank) begin
         w_grant = GNT_WR;
      end else if (rd_valid && wr_valid) begin
         // Round-robin on contention; NONE history favours the reader.
         w_grant = (r_last_grant == GNT_RD) ? GNT_WR : GNT_RD;
      end else if (rd_valid) begin
         w_grant = GNT_RD;
      end else if (wr_valid) begin
         w_grant = GNT_WR;
      end
   end

   assign rd_ready = (w_grant == GNT_RD);
   assign wr_ready = (w_grant == GNT_WR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= GNT_NONE;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         mem_en <= (w_grant != GNT_NONE);
         mem_we <= (w_grant == GNT_WR);
         if (w_grant == GNT_RD) begin
            r_last_grant <= GNT_RD;
            mem_addr     <= rd_addr;
         end else if (w_grant == GNT_WR) begin
            r_last_grant <= GNT_WR;
            mem_addr     <= wr_addr;
            mem_wdata    <= wr_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_wr_stall <= '0;
      end else if (stat_clr) begin
         stat_wr_stall <= '0;
      end else if (wr_valid && !wr_ready && (stat_wr_stall != '1)) begin
         stat_wr_stall <= stat_wr_stall + 16'd1;
      end
   end

   assign w_mem_rd = mem_en & ~mem_we;

   vga_rd_lat_pipe #(
      .LAT (MEM_RD_LAT)
   ) u_rd_lat_pipe (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (w_mem_rd),
      .o_valid (rd_data_valid)
   );

   assign rd_data = rd_data_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter with a 3-cycle-latency RAM model: arbitration vector table
// plus hand-written multi-cycle sequences.
module tb_vga_fb_arbiter;

   localparam int unsigned AW  = 17;
   localparam int unsigned DW  = 16;
   localparam int unsigned LAT = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          disp_vblank, disp_urgent;
   logic          rd_valid, wr_valid;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_ready, wr_ready, rd_data_valid;
   logic [DW-1:0] rd_data;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          stat_clr;
   logic [15:0]   stat_wr_stall;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vga_fb_arbiter #(
      .AW         (AW),
      .DW         (DW),
      .MEM_RD_LAT (LAT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .disp_vblank   (disp_vblank),
      .disp_urgent   (disp_urgent),
      .rd_valid      (rd_valid),
      .rd_addr       (rd_addr),
      .rd_ready      (rd_ready),
      .rd_data_valid (rd_data_valid),
      .rd_data       (rd_data),
      .wr_valid      (wr_valid),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_ready      (wr_ready),
      .mem_en        (mem_en),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .stat_clr      (stat_clr),
      .stat_wr_stall (stat_wr_stall)
   );

   // RAM model: 256 words, read data appears LAT cycles after the mem_en cycle.
   logic [DW-1:0] ram [0:255];
   logic [DW-1:0] rdq [0:LAT-1];

   always @(posedge clk) begin
      if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      rdq[0] <= ram[mem_addr[7:0]];
      for (int i = 1; i < LAT; i++) rdq[i] <= rdq[i-1];
   end
   assign mem_rdata = rdq[LAT-1];

   typedef struct {
      logic          rv, wv, urg, vb;
      logic [AW-1:0] ra, wa;
      logic          er, ew;
   } vec_t;

   localparam int NV = 14;
   vec_t vec [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      rd_valid = 0; wr_valid = 0; disp_urgent = 0; disp_vblank = 0; stat_clr = 0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
   endtask

   logic [DW-1:0] pat [4];
   logic          seen;

   initial begin
      rst = 1'b1;
      idle_inputs();
      pat[0] = 16'hF800; pat[1] = 16'h07E0; pat[2] = 16'h001F; pat[3] = 16'hFFFF;

      //              rv wv ur vb  ra      wa     er ew
      vec[0]  = '{0, 0, 0, 0, 17'h00, 17'h00, 0, 0};
      vec[1]  = '{1, 0, 0, 0, 17'h10, 17'h00, 1, 0};
      vec[2]  = '{1, 1, 0, 0, 17'h11, 17'h20, 0, 1};
      vec[3]  = '{1, 1, 0, 0, 17'h11, 17'h21, 1, 0};
      vec[4]  = '{1, 1, 0, 0, 17'h12, 17'h21, 0, 1};
      vec[5]  = '{0, 0, 0, 0, 17'h00, 17'h00, 0, 0};
      vec[6]  = '{1, 1, 0, 0, 17'h12, 17'h22, 1, 0};
      vec[7]  = '{1, 1, 1, 0, 17'h13, 17'h22, 1, 0};
      vec[8]  = '{1, 1, 0, 1, 17'h14, 17'h22, 0, 1};
      vec[9]  = '{1, 1, 1, 1, 17'h14, 17'h23, 1, 0};
      vec[10] = '{0, 1, 1, 0, 17'h00, 17'h23, 0, 1};
      vec[11] = '{1, 0, 0, 1, 17'h15, 17'h00, 1, 0};
      vec[12] = '{0, 1, 0, 0, 17'h00, 17'h24, 0, 1};
      vec[13] = '{1, 1, 0, 0, 17'h16, 17'h25, 1, 0};

      // Reset state
      do_reset();
      #1;
      check("rst rd_ready", rd_ready, 0);
      check("rst wr_ready", wr_ready, 0);
      check("rst rd_data_valid", rd_data_valid, 0);
      check("rst rd_data", rd_data, 0);
      check("rst mem_en", mem_en, 0);
      check("rst mem_we", mem_we, 0);
      check("rst mem_addr", mem_addr, 0);
      check("rst mem_wdata", mem_wdata, 0);
      check("rst stat", stat_wr_stall, 0);

      // First read: ready at N, mem access at N+1, data valid at N+1+LAT
      @(negedge clk); rd_valid = 1; rd_addr = 17'h5; #1;
      check("first rd_ready", rd_ready, 1);
      check("first wr_ready", wr_ready, 0);
      @(negedge clk); rd_valid = 0; #1;
      check("first mem_en", mem_en, 1);
      check("first mem_we", mem_we, 0);
      check("first mem_addr", mem_addr, 17'h5);
      check("first rdv N+1", rd_data_valid, 0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); #1;
         check("first rd_data_valid", rd_data_valid, (k == LAT) ? 1 : 0);
      end

      // Arbitration table; mem_* of vector i-1 checked alongside vector i
      for (int i = 0; i <= NV; i++) begin
         @(negedge clk);
         if (i < NV) begin
            rd_valid = vec[i].rv; wr_valid = vec[i].wv;
            disp_urgent = vec[i].urg; disp_vblank = vec[i].vb;
            rd_addr = vec[i].ra; wr_addr = vec[i].wa; wr_data = 16'hA000 | 16'(vec[i].wa);
         end else begin
            idle_inputs();
         end
         #1;
         if (i < NV) begin
            check("tbl rd_ready", rd_ready, vec[i].er);
            check("tbl wr_ready", wr_ready, vec[i].ew);
         end
         if (i > 0) begin
            check("tbl mem_en", mem_en, vec[i-1].er | vec[i-1].ew);
            check("tbl mem_we", mem_we, vec[i-1].ew);
            if (vec[i-1].er) check("tbl rd mem_addr", mem_addr, vec[i-1].ra);
            if (vec[i-1].ew) begin
               check("tbl wr mem_addr", mem_addr, vec[i-1].wa);
               check("tbl mem_wdata", mem_wdata, 16'hA000 | 16'(vec[i-1].wa));
            end
         end
      end
      check("tbl stall count", stat_wr_stall, 5);

      // Clear, then 10 urgent cycles with both requesters pending
      @(negedge clk); stat_clr = 1;
      @(negedge clk); stat_clr = 0; #1;
      check("clr stat", stat_wr_stall, 0);
      rd_valid = 1; wr_valid = 1; disp_urgent = 1;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         rd_addr = 17'(k); #1;
         check("urg rd_ready", rd_ready, 1);
         check("urg wr_ready", wr_ready, 0);
      end
      @(negedge clk); idle_inputs(); #1;
      check("urg stall=10", stat_wr_stall, 10);

      // Urgent beats vblank; once urgent drops, vblank gives the writer every cycle
      @(negedge clk); rd_valid = 1; wr_valid = 1; disp_urgent = 1; disp_vblank = 1; #1;
      check("urg+vb rd_ready", rd_ready, 1);
      check("urg+vb wr_ready", wr_ready, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); disp_urgent = 0; wr_addr = 17'h40 + 17'(k); #1;
         check("vb wr_ready", wr_ready, 1);
         check("vb rd_ready", rd_ready, 0);
      end

      // Preload 0..3 via the writer, drain, then a 4-read burst
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         rd_valid = 0; disp_urgent = 0; disp_vblank = 1; wr_valid = 1;
         wr_addr = 17'(k); wr_data = pat[k]; #1;
         check("preload wr_ready", wr_ready, 1);
      end
      @(negedge clk); idle_inputs();
      repeat (6) @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         rd_valid = (c < 4); rd_addr = 17'(c); #1;
         if (c < 4) check("burst rd_ready", rd_ready, 1);
         check("burst rd_data_valid", rd_data_valid, (c >= 4 && c < 8) ? 1 : 0);
         if (c >= 4 && c < 8) check("burst rd_data", rd_data, pat[c-4]);
      end
      idle_inputs();

      // Reset one cycle after a read grant discards the in-flight read
      @(negedge clk); rd_valid = 1; rd_addr = 17'h1; #1;
      check("midrst rd_ready", rd_ready, 1);
      @(negedge clk); rd_valid = 0; rst = 1; #1;
      check("midrst mem_en async", mem_en, 0);
      @(negedge clk); @(negedge clk); rst = 0;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); #1;
         if (rd_data_valid) seen = 1;
      end
      check("midrst no rd_data_valid", seen, 0);

      // Stall counter saturation, then clear-wins while still stalling
      @(negedge clk); rd_valid = 1; wr_valid = 1; disp_urgent = 1;
      repeat (65540) @(negedge clk);
      #1;
      check("stall saturate", stat_wr_stall, 16'hFFFF);
      stat_clr = 1;
      @(negedge clk); stat_clr = 0; #1;
      check("stall clr wins", stat_wr_stall, 0);
      idle_inputs();
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
